// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux_scan channel multiplexer.
package mux_scan_pkg;

  // Upper bound on channel count the search helper can handle.
  localparam int MAX_CH = 32;

  typedef enum logic [1:0] {
    S_MAN  = 2'd0,
    S_SCAN = 2'd1,
    S_IDLE = 2'd2
  } state_t;

  // Out-of-range manual selects fall back to channel 0.
  function automatic int clamp_sel(input int sel, input int n_ch);
    return (sel >= n_ch) ? 0 : sel;
  endfunction

  // Wrap-around priority search: first set bit strictly above cur,
  // otherwise the lowest set bit. Returns 0 for an empty mask.
  function automatic int next_en(input int cur, input logic [MAX_CH-1:0] mask,
                                 input int n_ch);
    int   idx;
    logic found;
    next_en = 0;
    found   = 1'b0;
    for (int k = 1; k <= MAX_CH; k++) begin
      idx = cur + k;
      if (idx >= n_ch) idx = idx - n_ch;
      if (!found && (k <= n_ch) && mask[idx[4:0]]) begin
        next_en = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mux_scan_rr_next_sel.sv
// Combinational wrap-around finder for the next enabled channel.
// inclusive=1 accepts start itself; inclusive=0 searches strictly above it.
module rr_next_sel
  import mux_scan_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] mask,
  input  logic [CH_W-1:0] start,
  input  logic            inclusive,
  output logic [CH_W-1:0] idx
);

  int from_idx;

  // An inclusive search is an exclusive search from the channel just below start.
  always_comb begin
    from_idx = int'(start);
    if (inclusive) from_idx = (from_idx == 0) ? (N_CH - 1) : (from_idx - 1);
    idx = CH_W'(next_en(from_idx, MAX_CH'(mask), N_CH));
  end

endmodule

// File: rtl/mux_scan.sv
// N-channel registered multiplexer with manual select and round-robin auto-scan.
// dout_vld qualifies dout/dout_ch each cycle; there is no back-pressure, the
// consumer must take data whenever dout_vld is high.
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int W     = 8,
  parameter  int DWELL = 4,
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [CH_W-1:0]   sel,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [N_CH*W-1:0] din,
  output logic [W-1:0]      dout,
  output logic [CH_W-1:0]   dout_ch,
  output logic              dout_vld,
  output logic              ch_sw,
  output logic [1:0]        dbg_state
);

  localparam int             DW         = $clog2(DWELL) + 1;
  localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL - 1);

  state_t          state_q, state_nxt;
  logic [CH_W-1:0] cur_ch, ch_nxt, adv_ch, ent_ch;
  logic [DW-1:0]   dwell_cnt, cnt_nxt;
  logic            vld_nxt;
  logic            armed_q;
  logic [W-1:0]    data_nxt;

  assign dbg_state = state_q;

  rr_next_sel #(.N_CH(N_CH)) u_adv (
    .mask(ch_en), .start(cur_ch), .inclusive(1'b0), .idx(adv_ch)
  );

  rr_next_sel #(.N_CH(N_CH)) u_ent (
    .mask(ch_en), .start(cur_ch), .inclusive(1'b1), .idx(ent_ch)
  );

  // State is a pure function of the current mode and enable mask.
  always_comb begin
    if (!mode)       state_nxt = S_MAN;
    else if (|ch_en) state_nxt = S_SCAN;
    else             state_nxt = S_IDLE;
  end

  // Pick the channel to forward at this edge and the next dwell count.
  always_comb begin
    ch_nxt  = cur_ch;
    cnt_nxt = '0;
    case (state_nxt)
      S_MAN: ch_nxt = CH_W'(clamp_sel(int'(sel), N_CH));
      S_SCAN: begin
        if (state_q != S_SCAN)                          ch_nxt = ent_ch;
        else if (!ch_en[cur_ch] || dwell_cnt == DWELL_LAST) ch_nxt = adv_ch;
        else                                            cnt_nxt = DW'(dwell_cnt + 1'b1);
      end
      default: ch_nxt = cur_ch;
    endcase
    vld_nxt  = (state_nxt != S_IDLE);
    data_nxt = din[ch_nxt*W +: W];
  end

  // State, dwell counter and output registers; idle holds dout/dout_ch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cur_ch    <= '0;
      dwell_cnt <= '0;
      dout      <= '0;
      dout_ch   <= '0;
      dout_vld  <= 1'b0;
      ch_sw     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cur_ch    <= ch_nxt;
      dwell_cnt <= cnt_nxt;
      dout_vld  <= vld_nxt;
      ch_sw     <= armed_q && vld_nxt && (ch_nxt != dout_ch);
      armed_q   <= 1'b1;
      if (vld_nxt) begin
        dout    <= data_nxt;
        dout_ch <= ch_nxt;
      end
    end
  end

endmodule
